// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes in ID and carries control through EX, MEM, WB.
// Define CU_LOAD_USE_STALL_EN to enable the internal load-use interlock.

package pipe_cu_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } aluop_t;
endpackage

module pipe_control_unit
    import pipe_cu_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WORD_W-1:0]  id_instr,
    input  logic               id_valid,
    input  logic               flush,
    input  logic               dhit,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_extop,
    output logic               ex_regdst,
    output logic [REG_W-1:0]   ex_shamt,
    output logic [1:0]         ex_pc_src,
    output logic               ex_beq,
    output logic               ex_bne,
    output logic               mem_dREN,
    output logic               mem_dWEN,
    output logic               wb_regwr,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_wsel,
    output logic               pc_hold,
    output logic               halt
);

    typedef struct packed {
        aluop_t           alu_op;
        logic             alu_src;
        logic             extop;
        logic             regdst;
        logic [REG_W-1:0] shamt;
        logic [1:0]       pc_src;
        logic             beq;
        logic             bne;
        logic             dren;
        logic             dwen;
        logic             regwr;
        logic             memtoreg;
        logic [REG_W-1:0] wsel;
        logic             halt;
    } idex_t;

    typedef struct packed {
        logic             dren;
        logic             dwen;
        logic             regwr;
        logic             memtoreg;
        logic [REG_W-1:0] wsel;
        logic             halt;
    } exmem_t;

    typedef struct packed {
        logic             regwr;
        logic             memtoreg;
        logic [REG_W-1:0] wsel;
        logic             halt;
    } memwb_t;

`ifdef CU_LOAD_USE_STALL_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    idex_t  idex_q, idex_d, dec, id_word;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic   halting_q, halting_d;
    logic   halt_q, halt_d;
    logic   uses_rs, uses_rt, id_live;
    logic   mem_stall, load_use;

    logic [5:0]       op, fn;
    logic [REG_W-1:0] rs, rt, rd, sh;

    assign op = id_instr[31:26];
    assign fn = id_instr[5:0];
    assign rs = REG_W'(id_instr[25:21]);
    assign rt = REG_W'(id_instr[20:16]);
    assign rd = REG_W'(id_instr[15:11]);
    assign sh = REG_W'(id_instr[10:6]);

    always_comb begin
        dec     = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (op)
            6'h00: begin
                dec.regdst = 1'b1;
                dec.regwr  = 1'b1;
                dec.wsel   = rd;
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
                case (fn)
                    6'h21: dec.alu_op = ALU_ADD;
                    6'h23: dec.alu_op = ALU_SUB;
                    6'h24: dec.alu_op = ALU_AND;
                    6'h25: dec.alu_op = ALU_OR;
                    6'h26: dec.alu_op = ALU_XOR;
                    6'h27: dec.alu_op = ALU_NOR;
                    6'h2A: dec.alu_op = ALU_SLT;
                    6'h2B: dec.alu_op = ALU_SLTU;
                    6'h00: begin
                        dec.alu_op = ALU_SLL;
                        dec.shamt  = sh;
                    end
                    6'h02: begin
                        dec.alu_op = ALU_SRL;
                        dec.shamt  = sh;
                    end
                    6'h08: begin
                        dec.regdst = 1'b0;
                        dec.regwr  = 1'b0;
                        dec.wsel   = '0;
                        dec.pc_src = 2'd3;
                    end
                    default: begin
                        dec     = '0;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                    end
                endcase
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec.alu_src = 1'b1;
                dec.regwr   = 1'b1;
                dec.wsel    = rt;
                uses_rs     = (op != 6'h0F);
                dec.extop   = (op == 6'h09) || (op == 6'h0A) || (op == 6'h0B);
                case (op)
                    6'h09:   dec.alu_op = ALU_ADD;
                    6'h0A:   dec.alu_op = ALU_SLT;
                    6'h0B:   dec.alu_op = ALU_SLTU;
                    6'h0C:   dec.alu_op = ALU_AND;
                    6'h0D:   dec.alu_op = ALU_OR;
                    6'h0E:   dec.alu_op = ALU_XOR;
                    default: dec.alu_op = ALU_LUI;
                endcase
            end
            6'h23: begin
                dec.alu_op   = ALU_ADD;
                dec.alu_src  = 1'b1;
                dec.extop    = 1'b1;
                dec.dren     = 1'b1;
                dec.regwr    = 1'b1;
                dec.memtoreg = 1'b1;
                dec.wsel     = rt;
                uses_rs      = 1'b1;
            end
            6'h2B: begin
                dec.alu_op  = ALU_ADD;
                dec.alu_src = 1'b1;
                dec.extop   = 1'b1;
                dec.dwen    = 1'b1;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            6'h04, 6'h05: begin
                dec.alu_op = ALU_SUB;
                dec.extop  = 1'b1;
                dec.pc_src = 2'd1;
                dec.beq    = (op == 6'h04);
                dec.bne    = (op == 6'h05);
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
            end
            6'h02: dec.pc_src = 2'd2;
            6'h03: begin
                dec.pc_src = 2'd2;
                dec.regwr  = 1'b1;
                dec.wsel   = REG_W'(31);
            end
            6'h3F: dec.halt = 1'b1;
            default: dec = '0;
        endcase
        if (dec.wsel == '0) dec.regwr = 1'b0;
    end

    // After HALT is accepted nothing else may enter the pipe.
    assign id_live = id_valid & ~halting_q;
    assign id_word = id_live ? dec : '0;

    assign mem_stall = (exmem_q.dren | exmem_q.dwen) & ~dhit;

    assign load_use = LU_EN && id_live && idex_q.dren &&
                      (idex_q.wsel != '0) &&
                      ((uses_rs && (rs == idex_q.wsel)) ||
                       (uses_rt && (rt == idex_q.wsel)));

    assign pc_hold = mem_stall | (load_use & ~flush);

    always_comb begin
        idex_d    = idex_q;
        exmem_d   = exmem_q;
        memwb_d   = memwb_q;
        halting_d = halting_q;
        halt_d    = halt_q | memwb_q.halt;
        if (!mem_stall) begin
            memwb_d.regwr    = exmem_q.regwr;
            memwb_d.memtoreg = exmem_q.memtoreg;
            memwb_d.wsel     = exmem_q.wsel;
            memwb_d.halt     = exmem_q.halt;
            exmem_d.dren     = idex_q.dren;
            exmem_d.dwen     = idex_q.dwen;
            exmem_d.regwr    = idex_q.regwr;
            exmem_d.memtoreg = idex_q.memtoreg;
            exmem_d.wsel     = idex_q.wsel;
            exmem_d.halt     = idex_q.halt;
            if (flush || load_use) begin
                idex_d = '0;
            end else begin
                idex_d = id_word;
                if (id_word.halt) halting_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            halting_q <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            halting_q <= halting_d;
            halt_q    <= halt_d;
        end
    end

    assign ex_alu_op   = ALUOP_W'(idex_q.alu_op);
    assign ex_alu_src  = idex_q.alu_src;
    assign ex_extop    = idex_q.extop;
    assign ex_regdst   = idex_q.regdst;
    assign ex_shamt    = idex_q.shamt;
    assign ex_pc_src   = idex_q.pc_src;
    assign ex_beq      = idex_q.beq;
    assign ex_bne      = idex_q.bne;
    assign mem_dREN    = exmem_q.dren;
    assign mem_dWEN    = exmem_q.dwen;
    assign wb_regwr    = memwb_q.regwr;
    assign wb_memtoreg = memwb_q.memtoreg;
    assign wb_wsel     = memwb_q.wsel;
    assign halt        = halt_q | memwb_q.halt;

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Parametrised, pipelined successor to the single-cycle control unit. It decodes the instruction in ID and carries the control word through ID/EX, EX/MEM and MEM/WB registers. Each stage can stall or flush, and the block holds data-cache requests until `dhit`. It sits between the fetch latch and the datapath of each core, and drives the per-stage control buses that the single-cycle unit used to drive combinationally.

## Interface
Parameters:
- `WORD_W`, 32, instruction width.
- `REG_W`, 5, register-index width (rs/rt/rd/wsel/shamt).
- `ALUOP_W`, 4, width of `aluop_t` encoding.

Ports:
- `CLK` in 1: core clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `id_instr` in WORD_W: instruction in ID.
- `id_valid` in 1: `id_instr` is real; 0 means bubble.
- `flush` in 1: branch/jump resolved taken in EX; kill ID.
- `dhit` in 1: dcache completed current request.
- `ex_alu_op` out ALUOP_W: ALU operation for EX.
- `ex_alu_src`, `ex_extop`, `ex_regdst` out 1: operand select, sign/zero extension and destination select for EX.
- `ex_shamt` out REG_W: shift amount for EX.
- `ex_pc_src` out 2: 0 = PC+4, 1 = branch, 2 = jump, 3 = JR.
- `ex_beq`, `ex_bne` out 1: branch type for EX.
- `mem_dREN`, `mem_dWEN` out 1: dcache read/write request in MEM.
- `wb_regwr`, `wb_memtoreg` out 1: writeback enable and source select.
- `wb_wsel` out REG_W: writeback register index.
- `pc_hold` out 1: fetch/PC and ID latch must not advance.
- `halt` out 1: sticky halt.

## Operation
- Decode is combinational from `id_instr` and is registered into ID/EX.
- R-type (op 0x00) functs: ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLTU 0x2B, SLL 0x00, SRL 0x02, JR 0x08.
- I/J-type opcodes: ADDIU 09, ANDI 0C, ORI 0D, XORI 0E, SLTI 0A, SLTIU 0B, LUI 0F, LW 23, SW 2B, BEQ 04, BNE 05, J 02, JAL 03, HALT 3F.
- Unknown opcode or funct decodes as a bubble (all controls 0).
- `wsel` rules:
  - R-type: rd.
  - I-type: rt.
  - JAL: 31.
  - Any `wsel` of 0 forces `regwr` = 0.
- A bubble is an all-zero control word. It is inserted when `id_valid` = 0, when `flush` = 1, or by the load-use rule.
- Memory stall: `mem_dREN | mem_dWEN` with `dhit` = 0 gives `pc_hold` = 1, and all three stage registers hold.
  - On the `dhit` cycle the stall releases.
  - On the next edge, MEM/WB captures the MEM stage with `dREN`/`dWEN` cleared, so the request is not reissued.
- Halt:
  - HALT in ID sets an internal `halting` flag; all later ID instructions become bubbles.
  - `halt` asserts when HALT reaches WB and stays 1 until `RST`.
- Priority when events coincide: memory stall > flush > load-use > normal advance.
  - `flush` is sampled only when no memory stall is active; the branch unit holds `flush` until `pc_hold` = 0.

## Timing
- Latency: instruction valid in ID at cycle n → EX controls at n+1, MEM at n+2, WB at n+3 (no stalls).
- Reset: every output is 0 and every stage register holds a bubble. `halting` and `halt` are 0, `ex_pc_src` = 0 and `pc_hold` = 0.
- `RST` mid-stall discards all in-flight controls on that edge; no request survives.
- `pc_hold` is combinational from stage registers and `dhit`, valid in the same cycle.
- Branch/jump in EX with `flush` = 1: the ID instruction becomes a bubble in EX at the next edge. There is no delay slot.
- Back-to-back stores/loads each hold MEM until their own `dhit`.

## Configuration
- `CU_LOAD_USE_STALL_EN` defined:
  - If EX holds LW (`mem_dREN` next) with `wsel` ≠ 0, and the ID instruction reads that register as rs (or as rt for R-type, SW, BEQ or BNE):
    - `pc_hold` = 1 for one cycle;
    - ID holds;
    - a bubble enters EX.
- Undefined: no load-use detection. `pc_hold` reflects memory stalls only, and an external hazard unit handles load-use.

## Test plan
- Reset, then `RST` = 0 → all outputs 0. `id_instr` = 0x00221821 (ADDU $3,$1,$2) valid at cycle 1 → cycle 2: `ex_alu_op` = ADD, `ex_regdst` = 1; cycle 4: `wb_regwr` = 1, `wb_wsel` = 3.
- SW 0xAC220004, `dhit` low 3 cycles then high → `mem_dWEN` = 1 and `pc_hold` = 1 for 3 cycles. Release on the `dhit` cycle; `mem_dWEN` does not reappear.
- LW 0x8C220000 followed by ADDU 0x00421821, macro defined → one `pc_hold` cycle, bubble in EX, ADDU reaches WB with `wb_wsel` = 3 one cycle later than unstalled. Macro undefined → no `pc_hold`.
- BEQ in EX with `flush` = 1 while ADDU is in ID → ADDU never produces `wb_regwr`.
- HALT 0xFC000000 followed by ORI → `halt` = 1 three cycles after HALT in ID, ORI never writes back, and `halt` stays 1 until `RST`.
- `RST` asserted during a LW stall → next cycle all outputs are 0 and `pc_hold` = 0.
